// File: rtl/uart_tx_digitos_pkg.sv
// Shared definitions for the 7E1 ASCII-digit transmitter.
//   - frame constants (data bits, ASCII mapping targets)
//   - FSM state encodings for the character serializer and packet sequencer
//   - bcd2ascii: BCD digit -> 7-bit ASCII, '?' for non-BCD nibbles
package uart_tx_digitos_pkg;

  localparam int         DATA_BITS  = 7;
  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_ERR  = 7'h3F;

  typedef enum logic [2:0] {
    C_IDLE, C_START, C_DATA, C_PARITY, C_STOP
  } char_st_e;

  typedef enum logic {
    P_IDLE, P_RUN
  } pkt_st_e;

  function automatic logic [6:0] bcd2ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (ASCII_ZERO + {3'b000, d}) : ASCII_ERR;
  endfunction

endpackage

// File: rtl/uart_tx_digitos_char.sv
// One-character 7E1 serializer: start, 7 data bits LSB first, even parity, stop.
// Ports:
//   clk, rst    clock / synchronous active-high reset
//   start       begin a character (sampled in IDLE, and in the last stop-bit
//               cycle to chain the next character with no idle gap)
//   chr[6:0]    character captured together with start
//   tx          registered serial line, idle high
//   busy        serializer is mid-frame
//   fin         high during the last cycle of the stop bit
module uart_tx_char
  import uart_tx_digitos_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] chr,
  output logic       tx,
  output logic       busy,
  output logic       fin
);

  localparam int             CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);

  char_st_e      st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bitn, bitn_nxt;
  logic [6:0]    chr_q, chr_nxt;
  logic          tx_nxt;
  logic          last_clk;

  assign last_clk = (cnt == CNT_MAX);
  assign busy     = (st != C_IDLE);
  // Kept out of the next-state block so the parent's start logic can
  // depend on it without forming a combinational cycle.
  assign fin      = (st == C_STOP) && last_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= C_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      chr_q <= '0;
      tx    <= 1'b1;
    end else begin
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      bitn  <= bitn_nxt;
      chr_q <= chr_nxt;
      tx    <= tx_nxt;
    end
  end

  // tx_nxt is the level of the bit that begins on the coming edge, so the
  // line is registered and changes exactly on bit boundaries.
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    bitn_nxt = bitn;
    chr_nxt  = chr_q;
    tx_nxt   = tx;
    if (st != C_IDLE) cnt_nxt = last_clk ? '0 : cnt + 1'b1;
    case (st)
      C_IDLE: if (start) begin
        st_nxt  = C_START;
        chr_nxt = chr;
        tx_nxt  = 1'b0;
      end
      C_START: if (last_clk) begin
        st_nxt   = C_DATA;
        bitn_nxt = '0;
        tx_nxt   = chr_q[0];
      end
      C_DATA: if (last_clk) begin
        if (bitn == 3'(DATA_BITS - 1)) begin
          st_nxt = C_PARITY;
          tx_nxt = ^chr_q;
        end else begin
          bitn_nxt = bitn + 3'd1;
          tx_nxt   = chr_q[bitn + 3'd1];
        end
      end
      C_PARITY: if (last_clk) begin
        st_nxt = C_STOP;
        tx_nxt = 1'b1;
      end
      C_STOP: if (last_clk) begin
        if (start) begin
          st_nxt  = C_START;
          chr_nxt = chr;
          tx_nxt  = 1'b0;
        end else begin
          st_nxt = C_IDLE;
          tx_nxt = 1'b1;
        end
      end
      default: begin
        st_nxt = C_IDLE;
        tx_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx_digitos.sv
// Packet transmitter: on send, latches NUM_DIGITS BCD digits and sends each
// as an ASCII 7E1 character, most significant digit first, frames back to back.
// Ports:
//   clk, rst    clock / synchronous active-high reset
//   send        packet request, honoured only while busy=0
//   digits      BCD digits, top nibble sent first
//   tx          serial line, idle high
//   busy        high from the cycle after accept through the last stop-bit cycle
//   done        one-cycle pulse in the last stop-bit cycle of the packet
module uart_tx_digitos
  import uart_tx_digitos_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int NUM_DIGITS   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    send,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  pkt_st_e                 pst, pst_nxt;
  // Remaining digits, shifted left as each character starts so the top
  // nibble is always the next one to send.
  logic [4*NUM_DIGITS-1:0] dig_q, dig_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [3:0]              nib;
  logic                    last_chr;
  logic                    c_start, c_busy, c_fin;

  always_ff @(posedge clk) begin
    if (rst) begin
      pst   <= P_IDLE;
      dig_q <= '0;
      idx   <= '0;
    end else begin
      pst   <= pst_nxt;
      dig_q <= dig_nxt;
      idx   <= idx_nxt;
    end
  end

  assign busy     = (pst == P_RUN);
  assign last_chr = (idx == IW'(NUM_DIGITS - 1));

  // The first character is taken straight from the digits input so the
  // start bit appears on the edge that accepts send.
  always_comb begin
    pst_nxt = pst;
    dig_nxt = dig_q;
    idx_nxt = idx;
    c_start = 1'b0;
    done    = 1'b0;
    nib     = dig_q[4*NUM_DIGITS-1 -: 4];
    case (pst)
      P_IDLE: begin
        nib = digits[4*NUM_DIGITS-1 -: 4];
        if (send && !c_busy) begin
          c_start = 1'b1;
          pst_nxt = P_RUN;
          dig_nxt = digits << 4;
          idx_nxt = '0;
        end
      end
      P_RUN: if (c_fin) begin
        if (last_chr) begin
          pst_nxt = P_IDLE;
          done    = 1'b1;
        end else begin
          c_start = 1'b1;
          dig_nxt = dig_q << 4;
          idx_nxt = idx + 1'b1;
        end
      end
      default: pst_nxt = P_IDLE;
    endcase
  end

  uart_tx_char #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_char (
    .clk   (clk),
    .rst   (rst),
    .start (c_start),
    .chr   (bcd2ascii(nib)),
    .tx    (tx),
    .busy  (c_busy),
    .fin   (c_fin)
  );

endmodule

// File: tb/tb_uart_tx_digitos.sv
module tb_uart_tx_digitos;

  localparam int CPB = 12;
  localparam int ND  = 4;

  logic          clk = 1'b0;
  logic          rst, send;
  logic [4*ND-1:0] digits;
  logic          tx, busy, done;

  uart_tx_digitos #(.CLKS_PER_BIT(CPB), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .send(send), .digits(digits),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errs = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      if (errs <= 30) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Line levels of one character in transmit order: start, d0..d6, parity, stop.
  function automatic logic [9:0] frame_bits(input logic [3:0] d);
    logic [6:0] c;
    c = (d > 4'd9) ? 7'h3F : 7'h30 + {3'b000, d};
    return {1'b1, 1'($countones(c) % 2), c, 1'b0};
  endfunction

  // Reference model: queue of expected tx levels, one entry per cycle.
  logic mq[$];
  bit   chk_en = 0;

  task automatic push_packet(input logic [4*ND-1:0] d);
    logic [9:0] f;
    for (int i = 0; i < ND; i++) begin
      f = frame_bits(4'((d >> (4*(ND-1-i))) & 'hF));
      for (int b = 0; b < 10; b++)
        for (int k = 0; k < CPB; k++) mq.push_back(f[b]);
    end
  endtask

  bit m_bsy;
  always @(posedge clk) begin
    m_bsy = (mq.size() != 0);
    if (rst) mq.delete();
    else if (m_bsy) void'(mq.pop_front());
    else if (send) push_packet(digits);
  end

  // Per-cycle compare plus a 7E1 line decoder and activity counters.
  int   cyc = 0, busy_cnt = 0, done_cnt = 0, last_done_cyc = 0, last_fall_cyc = 0;
  logic prev_tx = 1'b1;
  bit   dec_on = 0;
  int   dec_pos = 0;
  logic [9:0] dec_bits;
  logic [6:0] rxq[$];
  logic       parq[$];

  always @(negedge clk) if (chk_en) begin
    cyc++;
    chk("tx", {31'd0, tx}, {31'd0, (mq.size() != 0) ? mq[0] : 1'b1});
    chk("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
    chk("done", {31'd0, done}, {31'd0, mq.size() == 1});
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin done_cnt++; last_done_cyc = cyc; end
    if (prev_tx === 1'b1 && tx === 1'b0) last_fall_cyc = cyc;
    prev_tx = tx;
    if (rst) dec_on = 0;
    else begin
      if (!dec_on && tx === 1'b0) begin dec_on = 1; dec_pos = 0; end
      if (dec_on) begin
        if (dec_pos % CPB == CPB/2) dec_bits[dec_pos/CPB] = tx;
        dec_pos++;
        if (dec_pos == 10*CPB) begin
          dec_on = 0;
          chk("dec_stop", {31'd0, dec_bits[9]}, 32'd1);
          chk("dec_parity_even", $countones(dec_bits[8:1]) % 2, 32'd0);
          rxq.push_back(dec_bits[7:1]);
          parq.push_back(dec_bits[8]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin tick(1); k++; end
    chk("wait_idle_timeout", {31'd0, k >= budget}, 32'd0);
  endtask

  task automatic chk_chars(input string nm, input logic [6:0] e0, e1, e2, e3);
    logic [6:0] e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_count"}, rxq.size(), 32'd4);
    for (int i = 0; i < 4 && i < rxq.size(); i++)
      chk({nm, "_char"}, {25'd0, rxq[i]}, {25'd0, e[i]});
  endtask

  int b0, d0, dc, k;
  logic [9:0] fb;

  initial begin
    rst = 1'b1; send = 1'b0; digits = '0;
    @(posedge clk); #1;
    chk_en = 1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);

    // Model pinned by hand-derived frames.
    fb = frame_bits(4'd1);
    chk("frame_1", {22'd0, fb}, {22'd0, 10'b1101100010});
    fb = frame_bits(4'hA);
    chk("frame_err", {22'd0, fb}, {22'd0, 10'b1001111110});

    // Reset mid-frame abandons the packet without a done pulse.
    d0 = done_cnt;
    digits = 16'h1234; send = 1'b1; tick(1); send = 1'b0;
    tick(50);
    rst = 1'b1; tick(1);
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    tick(2); rst = 1'b0;
    tick(3*CPB);
    chk("midrst_idle_tx", {31'd0, tx}, 32'd1);
    chk("midrst_no_done", done_cnt - d0, 32'd0);

    // 0651 with an ignored 9999 request mid-packet.
    rxq.delete(); parq.delete();
    b0 = busy_cnt; d0 = done_cnt;
    digits = 16'h0651; send = 1'b1; tick(1); send = 1'b0;
    chk("start_latency_tx", {31'd0, tx}, 32'd0);
    chk("start_latency_busy", {31'd0, busy}, 32'd1);
    tick(20*CPB);
    digits = 16'h9999; send = 1'b1; tick(1); send = 1'b0;
    wait_idle(50*CPB);
    tick(1);
    chk("pkt_busy_cycles", busy_cnt - b0, 40*CPB);
    chk("pkt_done_pulses", done_cnt - d0, 32'd1);
    chk_chars("pkt0651", 7'h30, 7'h36, 7'h35, 7'h31);
    if (parq.size() == 4)
      chk("pkt0651_par", {28'd0, parq[0], parq[1], parq[2], parq[3]}, 32'b0001);

    // Invalid BCD nibble maps to '?'.
    rxq.delete(); parq.delete();
    digits = 16'h0A03; send = 1'b1; tick(1); send = 1'b0;
    wait_idle(50*CPB);
    tick(1);
    chk_chars("pkt0A03", 7'h30, 7'h3F, 7'h30, 7'h33);
    if (parq.size() >= 2) chk("qmark_parity", {31'd0, parq[1]}, 32'd0);

    // send held high: no accept in the done cycle, accept the cycle after.
    d0 = done_cnt;
    digits = 16'h2718; send = 1'b1;
    k = 0;
    while (done_cnt == d0 && k < 60*CPB) begin tick(1); k++; end
    chk("held_done_timeout", {31'd0, k >= 60*CPB}, 32'd0);
    dc = last_done_cyc;
    k = 0;
    while (last_fall_cyc <= dc && k < 10) begin tick(1); k++; end
    chk("held_restart_gap", last_fall_cyc - dc, 32'd2);
    send = 1'b0;
    wait_idle(50*CPB);

    // Randomized packets with stray sends and occasional resets.
    for (int it = 0; it < 24; it++) begin
      digits = 16'($urandom); send = 1'b1;
      tick($urandom_range(1, 3));
      send = 1'b0; digits = 16'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        tick($urandom_range(1, 40*CPB));
        rst = 1'b1; tick($urandom_range(1, 3)); rst = 1'b0;
      end else begin
        tick($urandom_range(1, 30*CPB));
        send = 1'b1; tick(1); send = 1'b0;
        wait_idle(50*CPB);
      end
      tick($urandom_range(0, 4));
    end
    tick(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
